// File: rtl/register_bank_pkg.sv
// Shared definitions for register_bank: write-op encodings and address width helper.
package register_bank_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_bank_channel.sv
// One register_bank channel: op logic plus active copy, and a shadow copy
// when REGISTER_BANK_SHADOW_EN is defined.
module register_bank_channel
    import register_bank_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             commit,
    output logic [WIDTH-1:0] active,
    output logic             changed
);
    logic             write;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] next_active;

    assign write = sel & we;

    always_comb begin
        wr_val = base;
        unique case (op_e'(op))
            OP_LOAD: wr_val = d;
            OP_SET:  wr_val = base | d;
            OP_CLR:  wr_val = base & ~d;
            OP_TGL:  wr_val = base ^ d;
        endcase
    end

`ifdef REGISTER_BANK_SHADOW_EN
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] next_shadow;

    // A commit on the write edge forwards the freshly written shadow value.
    assign base        = shadow;
    assign next_shadow = write ? wr_val : shadow;
    assign next_active = commit ? next_shadow : active;

    always_ff @(negedge clock) begin
        if (reset) begin
            shadow <= RESET;
            active <= RESET;
        end else begin
            shadow <= next_shadow;
            active <= next_active;
        end
    end
`else
    logic commit_unused;

    assign commit_unused = commit;
    assign base          = active;
    assign next_active   = write ? wr_val : active;

    always_ff @(negedge clock) begin
        if (reset) active <= RESET;
        else       active <= next_active;
    end
`endif

    assign changed = (next_active != active);

endmodule

// File: rtl/register_bank.sv
// Multi-channel control register bank with load/set/clear/toggle writes.
// REGISTER_BANK_SHADOW_EN selects shadow+commit; otherwise writes go straight to active.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      CHANNELS = 4,
    parameter logic [WIDTH-1:0] RESET    = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               we,
    input  logic [1:0]                         op,
    input  logic [addr_width(CHANNELS)-1:0]    addr,
    input  logic [WIDTH-1:0]                   d,
    input  logic                               commit,
    input  logic [addr_width(CHANNELS)-1:0]    rd_addr,
    output logic [WIDTH-1:0]                   rd_data,
    output logic [CHANNELS*WIDTH-1:0]          q,
    output logic                               pending,
    output logic                               updated
);
    localparam int unsigned AW = addr_width(CHANNELS);

    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] changed;
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [WIDTH-1:0]    rd_next;

    // Out-of-range addresses match no channel: writes drop, reads return zero.
    always_comb begin
        sel     = '0;
        rd_next = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (addr == AW'(i))    sel[i]  = 1'b1;
            if (rd_addr == AW'(i)) rd_next = active[i];
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        register_bank_channel #(
            .WIDTH (WIDTH),
            .RESET (RESET)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .sel     (sel[i]),
            .we      (we),
            .op      (op),
            .d       (d),
            .commit  (commit),
            .active  (active[i]),
            .changed (changed[i])
        );
        assign q[i*WIDTH +: WIDTH] = active[i];
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            rd_data <= RESET;
            updated <= 1'b0;
        end else begin
            rd_data <= rd_next;
            updated <= |changed;
        end
    end

`ifdef REGISTER_BANK_SHADOW_EN
    logic addr_ok;

    assign addr_ok = |sel;

    always_ff @(negedge clock) begin
        if (reset)              pending <= 1'b0;
        else if (commit)        pending <= 1'b0;
        else if (we && addr_ok) pending <= 1'b1;
    end
`else
    assign pending = 1'b0;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank; expectations follow REGISTER_BANK_SHADOW_EN if defined.
module tb_register_bank;

`ifdef REGISTER_BANK_SHADOW_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    typedef enum {K_Q, K_RD, K_PEND, K_UPD, K_Q3, K_RD3, K_PEND3, K_UPD3} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0, commit = 1'b0;
    logic [1:0]  op = 2'b00, addr = 2'd0, rd_addr = 2'd0;
    logic [7:0]  d = 8'h00;
    logic [7:0]  rd_data;
    logic [31:0] q;
    logic        pending, updated;

    logic        we3 = 1'b0, commit3 = 1'b0;
    logic [1:0]  op3 = 2'b00, addr3 = 2'd0, rd_addr3 = 2'd0;
    logic [7:0]  d3 = 8'h00;
    logic [7:0]  rd_data3;
    logic [23:0] q3;
    logic        pending3, updated3;

    register_bank #(.WIDTH(8), .CHANNELS(4), .RESET(8'hA5)) u_dut (
        .clock(clock), .reset(reset), .we(we), .op(op), .addr(addr), .d(d),
        .commit(commit), .rd_addr(rd_addr), .rd_data(rd_data), .q(q),
        .pending(pending), .updated(updated)
    );

    register_bank #(.WIDTH(8), .CHANNELS(3), .RESET(8'h00)) u_dut3 (
        .clock(clock), .reset(reset), .we(we3), .op(op3), .addr(addr3), .d(d3),
        .commit(commit3), .rd_addr(rd_addr3), .rd_data(rd_data3), .q(q3),
        .pending(pending3), .updated(updated3)
    );

    always #5 clock = ~clock;

    function automatic void expect_val(input string name, input kind_e kind, input logic [31:0] exp);
        item_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = exp;
        sb.push_back(it);
    endfunction

    // Monitor: outputs only move on the falling edge, so compare on the rising edge.
    initial begin
        forever begin
            @(posedge clock);
            while (sb.size() > 0) begin
                item_t       it;
                logic [31:0] act;
                it = sb.pop_front();
                case (it.kind)
                    K_Q:     act = q;
                    K_RD:    act = {24'd0, rd_data};
                    K_PEND:  act = {31'd0, pending};
                    K_UPD:   act = {31'd0, updated};
                    K_Q3:    act = {8'd0, q3};
                    K_RD3:   act = {24'd0, rd_data3};
                    K_PEND3: act = {31'd0, pending3};
                    default: act = {31'd0, updated3};
                endcase
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [1:0] o, input logic [1:0] a,
                         input logic [7:0] dd, input logic c, input logic [1:0] ra);
        reset   = r;
        we      = w;
        op      = o;
        addr    = a;
        d       = dd;
        commit  = c;
        rd_addr = ra;
    endtask

    task automatic drive3(input logic w, input logic [1:0] o, input logic [1:0] a,
                          input logic [7:0] dd, input logic c, input logic [1:0] ra);
        we3      = w;
        op3      = o;
        addr3    = a;
        d3       = dd;
        commit3  = c;
        rd_addr3 = ra;
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    initial begin
        // Reset wins over a simultaneous write and commit
        drive(1, 1, 2'b00, 2'd0, 8'h11, 1, 2'd0);
        tick();
        expect_val("rst_q", K_Q, 32'hA5A5A5A5);
        expect_val("rst_rd", K_RD, 32'hA5);
        expect_val("rst_pend", K_PEND, 0);
        expect_val("rst_upd", K_UPD, 0);
        expect_val("rst_q3", K_Q3, 0);

        drive(0, 1, 2'b00, 2'd2, 8'h3C, 0, 2'd2);
        tick();
        expect_val("ld2_q", K_Q, S ? 32'hA5A5A5A5 : 32'hA53CA5A5);
        expect_val("ld2_pend", K_PEND, {31'd0, S});
        expect_val("ld2_upd", K_UPD, {31'd0, !S});
        expect_val("ld2_rd", K_RD, 32'hA5);

        drive(0, 0, 2'b00, 2'd0, 8'h00, 1, 2'd2);
        tick();
        expect_val("cm1_q", K_Q, 32'hA53CA5A5);
        expect_val("cm1_pend", K_PEND, 0);
        expect_val("cm1_upd", K_UPD, {31'd0, S});
        expect_val("cm1_rd", K_RD, S ? 32'hA5 : 32'h3C);

        drive(0, 0, 2'b00, 2'd0, 8'h00, 0, 2'd2);
        tick();
        expect_val("idle1_upd", K_UPD, 0);
        expect_val("idle1_rd", K_RD, 32'h3C);

        // Ch0: 00 -> set 0F -> clear 03 -> toggle FF = F3
        drive(0, 1, 2'b00, 2'd0, 8'h00, 0, 2'd0); tick();
        drive(0, 1, 2'b01, 2'd0, 8'h0F, 0, 2'd0); tick();
        drive(0, 1, 2'b10, 2'd0, 8'h03, 0, 2'd0); tick();
        drive(0, 1, 2'b11, 2'd0, 8'hFF, 0, 2'd0); tick();
        expect_val("ops_q", K_Q, S ? 32'hA53CA5A5 : 32'hA53CA5F3);
        expect_val("ops_pend", K_PEND, {31'd0, S});

        drive(0, 0, 2'b00, 2'd0, 8'h00, 1, 2'd0);
        tick();
        expect_val("cm2_q", K_Q, 32'hA53CA5F3);
        expect_val("cm2_upd", K_UPD, {31'd0, S});
        expect_val("cm2_pend", K_PEND, 0);

        // Loading the value already held: no active change
        drive(0, 1, 2'b00, 2'd1, 8'hA5, 0, 2'd0);
        tick();
        expect_val("same_upd", K_UPD, 0);
        expect_val("same_pend", K_PEND, {31'd0, S});

        drive(0, 1, 2'b00, 2'd1, 8'h77, 1, 2'd0);
        tick();
        expect_val("wc_q", K_Q, 32'hA53C77F3);
        expect_val("wc_pend", K_PEND, 0);
        expect_val("wc_upd", K_UPD, 1);

        drive(0, 0, 2'b00, 2'd0, 8'h00, 1, 2'd0);
        tick();
        expect_val("cm_nop_upd", K_UPD, 0);
        expect_val("cm_nop_q", K_Q, 32'hA53C77F3);

        // Ch3 accumulation: 00, set 0F, toggle FF (with commit) = F0
        drive(0, 1, 2'b00, 2'd3, 8'h00, 0, 2'd3); tick();
        drive(0, 1, 2'b01, 2'd3, 8'h0F, 0, 2'd3); tick();
        drive(0, 1, 2'b11, 2'd3, 8'hFF, 1, 2'd3); tick();
        expect_val("acc_q", K_Q, 32'hF03C77F3);
        expect_val("acc_upd", K_UPD, 1);
        expect_val("acc_rd", K_RD, S ? 32'hA5 : 32'h0F);

        drive(0, 0, 2'b00, 2'd0, 8'h00, 0, 2'd3);
        tick();
        expect_val("acc_rd2", K_RD, 32'hF0);
        expect_val("acc_upd2", K_UPD, 0);

        drive(0, 1, 2'b00, 2'd2, 8'h99, 0, 2'd3);
        tick();
        expect_val("pre_rst_pend", K_PEND, {31'd0, S});

        drive(1, 1, 2'b00, 2'd1, 8'h12, 1, 2'd3);
        tick();
        expect_val("rst2_q", K_Q, 32'hA5A5A5A5);
        expect_val("rst2_pend", K_PEND, 0);
        expect_val("rst2_upd", K_UPD, 0);
        expect_val("rst2_rd", K_RD, 32'hA5);

        // Shadows must also have been reset: a bare commit changes nothing
        drive(0, 0, 2'b00, 2'd0, 8'h00, 1, 2'd1);
        tick();
        expect_val("rst2_cm_q", K_Q, 32'hA5A5A5A5);
        expect_val("rst2_cm_upd", K_UPD, 0);
        expect_val("rst2_cm_rd", K_RD, 32'hA5);

        drive(0, 0, 2'b00, 2'd0, 8'h00, 0, 2'd0);

        // Three-channel instance: address 3 is out of range
        drive3(1, 2'b00, 2'd3, 8'hFF, 0, 2'd3);
        tick();
        expect_val("oor_q3", K_Q3, 0);
        expect_val("oor_pend3", K_PEND3, 0);
        expect_val("oor_upd3", K_UPD3, 0);

        drive3(0, 2'b00, 2'd0, 8'h00, 1, 2'd3);
        tick();
        expect_val("oor_cm_q3", K_Q3, 0);
        expect_val("oor_cm_upd3", K_UPD3, 0);

        drive3(1, 2'b00, 2'd2, 8'h5A, 1, 2'd3);
        tick();
        expect_val("c3_q3", K_Q3, 32'h5A0000);
        expect_val("c3_upd3", K_UPD3, 1);
        expect_val("c3_pend3", K_PEND3, 0);
        expect_val("c3_rd3", K_RD3, 0);

        drive3(0, 2'b00, 2'd0, 8'h00, 0, 2'd2);
        tick();
        expect_val("c3_rd3_ch2", K_RD3, 32'h5A);

        drive3(0, 2'b00, 2'd0, 8'h00, 0, 2'd3);
        tick();
        expect_val("c3_rd3_oor", K_RD3, 0);

        repeat (4) begin
            if (sb.size() != 0) @(posedge clock);
        end
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised multi-channel successor to the single-register primitive: CHANNELS registers of WIDTH bits, each with a shadow copy written by the host bus and an active copy driving the design. Writes support load, bit-set, bit-clear and toggle operations. A single commit strobe transfers all shadows to the active copies atomically, for example to update several MIDI/control registers glitch-free. The block sits between the VIC bus decode and the functional blocks that consume control registers.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of channels (≥1)
- RESET, 0, reset value of every shadow and active channel (WIDTH bits)
- AW (localparam), max(1, clog2(CHANNELS)), address width

- clock  in  1  single clock; all state updates on the falling edge of clock
- reset  in  1  synchronous, active-high; sampled on the falling edge of clock
- we  in  1  write strobe for the shadow selected by addr
- op  in  2  write operation: 00 load, 01 set, 10 clear, 11 toggle
- addr  in  AW  write channel select
- d  in  WIDTH  write data / bit mask
- commit  in  1  copy all shadows to active
- rd_addr  in  AW  read channel select (active copy)
- rd_data  out  WIDTH  registered active[rd_addr]
- q  out  CHANNELS*WIDTH  all active copies, channel i at bits [i*WIDTH +: WIDTH]
- pending  out  1  shadow written since last commit
- updated  out  1  one-cycle pulse: the last commit changed at least one active bit

## Operation
- Write (we=1, addr<CHANNELS): shadow[addr] becomes d (load), shadow|d (set), shadow&~d (clear) or shadow^d (toggle). pending is set to 1.
- Write with addr≥CHANNELS (non-power-of-2 CHANNELS): shadow unchanged, pending unchanged.
- Commit: active[i] is set to shadow[i] for all i in the same edge. pending clears to 0. updated is 1 for the next cycle if any active bit differed, otherwise 0.
- Simultaneous we and commit: the write result is forwarded, so the active copy receives the post-write shadow value. pending ends at 0.
- Commit with pending=0 is legal; updated stays 0.
- Read: rd_data is registered with the value active[rd_addr]. rd_addr≥CHANNELS reads 0.
- Reset has priority over we and commit. On reset, all shadow and active copies are set to RESET, q is RESET replicated, rd_data is RESET, and pending and updated are 0. Reset mid-write or mid-commit discards the operation.

## Timing
- Write to shadow: visible internally at the next falling edge. q is unaffected until commit.
- Commit to q: q changes at the falling edge where commit=1 is sampled; latency 1 edge.
- updated: asserted for exactly one cycle after the commit edge, then deasserted.
- rd_data: 1-edge latency from rd_addr/active change. A commit and read on the same edge return the pre-commit value.
- Back-to-back commits are allowed every cycle. Back-to-back writes to the same channel accumulate: set 0x0F then toggle 0xFF gives 0xF0.

## Configuration
- REGISTER_BANK_SHADOW_EN defined: shadow/commit behaviour as above.
- Not defined: no shadow storage. Writes update active directly at the write edge (q visible after 1 edge). commit is ignored, pending is tied 0, and updated pulses for one cycle after any write that changes active bits.

## Structure
- Shared package: op encodings OP_LOAD=2'b00, OP_SET=2'b01, OP_CLR=2'b10, OP_TGL=2'b11, and the AW derivation function.
- Sub-module register_bank_channel holds one channel's shadow and active copies plus the op logic. Its inputs are sel, we, op, d and commit; its outputs are the active value and a changed flag. The top level instantiates CHANNELS copies and handles the address decode, read mux, pending and updated.

## Test plan
- Reset with RESET=8'hA5, CHANNELS=4 -> q=32'hA5A5A5A5, rd_data=8'hA5, pending=0, updated=0.
- Load ch2=8'h3C without commit -> q unchanged and pending=1; commit -> q[23:16]=8'h3C, pending=0, one-cycle updated=1.
- Ch0 from 8'h00: set 8'h0F, clear 8'h03, toggle 8'hFF, commit -> q[7:0]=8'hF3.
- we (load ch1=8'h77) and commit on the same edge -> q[15:8]=8'h77 on that edge, pending=0, updated=1.
- Commit with no intervening write -> updated stays 0. CHANNELS=3, write addr=3 -> no change; read addr=3 -> rd_data=0.
- Reset asserted on the same edge as a write and commit -> all channels=RESET, pending=0. Repeat the first scenario with REGISTER_BANK_SHADOW_EN undefined: the write appears on q directly and commit has no effect.
